// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with redirect, fetch-fault detection and delay-slot tracking
module pc_unit #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]  TEXT_LO    = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]  TEXT_HI    = 32'h0000_4ffc,
  parameter logic [ADDR_W-1:0]  HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_nextPC,
  input  logic              i_isBranch_D,
  input  logic              i_excReq,
  input  logic              i_eret,
  input  logic [ADDR_W-1:0] i_EPC,
  output logic [ADDR_W-1:0] o_PC,
  output logic [4:0]        ExcCode_F,
  output logic              o_BD_F,
  output logic [ADDR_W-1:0] o_badPC,
  output logic [7:0]        o_fault_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [ADDR_W-1:0] badpc_q, badpc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fault;
  logic              advance;

  assign fault   = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  assign advance = i_excReq || i_eret || i_en;

  // Bookkeeping fires only when a faulting PC is left, so a stalled fault counts once.
  always_comb begin
    pc_d    = pc_q;
    bd_d    = bd_q;
    badpc_d = badpc_q;
    cnt_d   = cnt_q;
    if (i_excReq) begin
      pc_d = HANDLER_PC;
      bd_d = 1'b0;
    end else if (i_eret) begin
      pc_d = i_EPC;
      bd_d = 1'b0;
    end else if (i_en) begin
      pc_d = i_nextPC;
      bd_d = i_isBranch_D;
    end
    if (advance && fault) begin
      badpc_d = pc_q;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
      badpc_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      badpc_q <= badpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_PC        = pc_q;
  assign o_BD_F      = bd_q;
  assign o_badPC     = badpc_q;
  assign o_fault_cnt = cnt_q;
  assign ExcCode_F   = fault ? 5'd4 : 5'd0;

endmodule
